// File: rtl/pixel_pkg.sv
// pixel_pkg -- shared pixel word layout for the fader, the ring buffer and
// the display scan-out.
//   Word layout: [9:0] X, [19:10] Y, [31:20] intensity (0 = empty slot).
//   Provides field positions/widths, INT_MAX, the packed word typedef, the
//   20-bit coordinate typedef queued by the fader FIFO, and a saturating
//   intensity subtract helper.
package pixel_pkg;

  localparam int X_LSB   = 0;
  localparam int X_W     = 10;
  localparam int Y_LSB   = 10;
  localparam int Y_W     = 10;
  localparam int INT_LSB = 20;
  localparam int INT_W   = 12;
  localparam int XY_W    = X_W + Y_W;
  localparam int WORD_W  = INT_W + XY_W;

  localparam logic [INT_W-1:0] INT_MAX  = 12'hFFF;
  localparam logic [INT_W-1:0] INT_ZERO = 12'h000;

  typedef struct packed {
    logic [INT_W-1:0] intensity;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   x;
  } pixel_word_t;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } pixel_xy_t;

  // Intensity minus step, clamped at zero.
  function automatic logic [INT_W-1:0] sat_sub(input logic [INT_W-1:0] a,
                                               input logic [INT_W-1:0] b);
    logic [INT_W-1:0] res;
    if (a > b) begin
      res = a - b;
    end else begin
      res = INT_ZERO;
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo -- synchronous FIFO of plotted pixel coordinates.
//   clock, reset : clock and asynchronous active-high reset (empties FIFO)
//   push, push_data : write request and coordinates (ignored when full)
//   pop          : read request (ignored when empty)
//   head         : oldest entry, valid while empty is low
//   full, empty  : registered occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
import pixel_pkg::*;

module pixel_fifo #(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  pixel_xy_t push_data,
  input  logic      pop,
  output pixel_xy_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  pixel_xy_t       mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic [AW:0]     count_next_s;
  logic            full_r;
  logic            empty_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;
  assign head      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_ok_s && !push_ok_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_DEPTH);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pixel_fader.sv
// pixel_fader -- inserts newly plotted pixels into a recirculating ring
// buffer and fades stored pixels once every FADE_PASSES revolutions.
//   clock, reset  : sole clock, asynchronous active-high reset
//   ring_out      : word leaving the ring buffer
//   ring_in       : word entering the ring buffer (registered, latency 1)
//   pixel_valid, pixel_x, pixel_y : new plotted pixel
//   pixel_ready   : FIFO can accept a pixel this cycle
//   dropped_count : saturating count of rejected pixels
// Build option: define PIXEL_FADER_STATS_EN to enable dropped_count;
// otherwise it is tied to zero and the counter is not built.
import pixel_pkg::*;

module pixel_fader #(
  parameter int               FIFO_DEPTH  = 16,
  parameter logic [INT_W-1:0] FADE_STEP   = 12'd16,
  parameter int               FADE_PASSES = 4,
  parameter int               RING_LEN    = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ring_out,
  output logic [31:0] ring_in,
  input  logic        pixel_valid,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        pixel_ready,
  output logic [15:0] dropped_count
);

  localparam int POS_W  = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
  localparam int PASS_W = (FADE_PASSES > 1) ? $clog2(FADE_PASSES) : 1;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(RING_LEN - 1);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]  POS_ZERO  = {POS_W{1'b0}};
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(FADE_PASSES - 1);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};

  pixel_word_t       in_word_s;
  pixel_word_t       ring_next_s;
  logic [31:0]       ring_r;
  logic [POS_W-1:0]  pos_r;
  logic [PASS_W-1:0] pass_r;
  logic              fade_pass_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  pixel_xy_t         head_s;
  pixel_xy_t         push_data_s;

  assign in_word_s     = ring_out;
  assign fade_pass_s   = (pass_r == PASS_ZERO);
  assign push_s        = pixel_valid && !fifo_full_s;
  assign push_data_s.x = pixel_x;
  assign push_data_s.y = pixel_y;
  assign pixel_ready   = !fifo_full_s;
  assign ring_in       = ring_r;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Insert into empty slots first; a fresh insert bypasses the fade, and any
  // word whose intensity is or becomes zero is emitted as an all-zero slot.
  always_comb begin
    ring_next_s = in_word_s;
    pop_s       = 1'b0;
    if (in_word_s.intensity == INT_ZERO) begin
      if (!fifo_empty_s) begin
        ring_next_s.intensity = INT_MAX;
        ring_next_s.y         = head_s.y;
        ring_next_s.x         = head_s.x;
        pop_s                 = 1'b1;
      end else begin
        ring_next_s = '0;
      end
    end else if (fade_pass_s) begin
      if (sat_sub(in_word_s.intensity, FADE_STEP) == INT_ZERO) begin
        ring_next_s = '0;
      end else begin
        ring_next_s.intensity = sat_sub(in_word_s.intensity, FADE_STEP);
      end
    end else begin
      ring_next_s = in_word_s;
    end
  end

  // Output word register, one cycle behind ring_out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ring_r <= 32'h0000_0000;
    end else begin
      ring_r <= ring_next_s;
    end
  end

  // Ring position and revolution counters; pass 0 is the fade revolution.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_r  <= POS_ZERO;
      pass_r <= PASS_ZERO;
    end else begin
      if (pos_r == POS_LAST) begin
        pos_r <= POS_ZERO;
        if (pass_r == PASS_LAST) begin
          pass_r <= PASS_ZERO;
        end else begin
          pass_r <= pass_r + PASS_ONE;
        end
      end else begin
        pos_r <= pos_r + POS_ONE;
      end
    end
  end

`ifdef PIXEL_FADER_STATS_EN
  logic [15:0] dropped_r;

  // Count pixels offered while the FIFO is full, stopping at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped_r <= 16'h0000;
    end else if (pixel_valid && fifo_full_s && (dropped_r != 16'hFFFF)) begin
      dropped_r <= dropped_r + 16'h0001;
    end
  end

  assign dropped_count = dropped_r;
`else
  assign dropped_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_fader.sv
// tb_pixel_fader -- directed scenarios plus randomized traffic for
// pixel_fader, checked every cycle against a queue-based reference model.
module tb_pixel_fader;
  import pixel_pkg::*;

  localparam int         DEPTH = 16;
  localparam int         RLEN  = 8;
  localparam int         NPASS = 2;
  localparam logic [11:0] STEP = 12'd16;
`ifdef PIXEL_FADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ring_out = 32'h0;
  logic [31:0] ring_in;
  logic        pixel_valid = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        pixel_ready;
  logic [15:0] dropped_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [19:0] q[$];
  int          n = 0;
  int          drops = 0;
  logic [31:0] exp_ring = 32'h0;

  always #5 clock = ~clock;

  pixel_fader #(
    .FIFO_DEPTH (DEPTH),
    .FADE_STEP  (STEP),
    .FADE_PASSES(NPASS),
    .RING_LEN   (RLEN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ring_out     (ring_out),
    .ring_in      (ring_in),
    .pixel_valid  (pixel_valid),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_ready  (pixel_ready),
    .dropped_count(dropped_count)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the spec's behaviour, from the inputs present at it.
  task automatic model_edge();
    logic [11:0] it;
    bit          fade;
    bit          acc;
    it   = ring_out[31:20];
    fade = ((n / RLEN) % NPASS) == 0;
    acc  = pixel_valid && (q.size() < DEPTH);
    if (pixel_valid && !acc && drops < 65535) drops++;
    if (it == 12'h000) begin
      if (q.size() > 0) begin
        exp_ring = {12'hFFF, q[0]};
        void'(q.pop_front());
      end else begin
        exp_ring = 32'h0;
      end
    end else if (fade) begin
      exp_ring = (it > STEP) ? {it - STEP, ring_out[19:0]} : 32'h0;
    end else begin
      exp_ring = ring_out;
    end
    if (acc) q.push_back({pixel_y, pixel_x});
    n++;
  endtask

  task automatic step(input logic v, input logic [9:0] x, input logic [9:0] y,
                      input logic [31:0] ro);
    pixel_valid = v;
    pixel_x     = x;
    pixel_y     = y;
    ring_out    = ro;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check32("ring_in", ring_in, exp_ring);
    check32("pixel_ready", {31'h0, pixel_ready}, {31'h0, (q.size() < DEPTH)});
    check32("dropped_count", {16'h0, dropped_count}, STATS ? 32'(drops) : 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    pixel_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check32("reset_ring_in", ring_in, 32'h0);
    check32("reset_ready", {31'h0, pixel_ready}, 32'h1);
    check32("reset_dropped", {16'h0, dropped_count}, 32'h0);
    q.delete();
    n        = 0;
    drops    = 0;
    exp_ring = 32'h0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int pct;
    logic [31:0] r;
    int sel;
    #1;
    do_reset();

    // Push (5,7) into an empty ring, inserted one edge after the push edge.
    step(1'b1, 10'd5, 10'd7, 32'h0);
    check32("no_bypass", ring_in, 32'h0);
    step(1'b0, 10'd0, 10'd0, 32'h0);
    check32("insert_5_7", ring_in, 32'hFFF01C05);
    // Fade in pass 0, fade-to-zero, then untouched in pass 1.
    step(1'b0, 10'd0, 10'd0, 32'h80000000);
    check32("fade_pass0", ring_in, 32'h7F000000);
    step(1'b0, 10'd0, 10'd0, 32'h00A00123);
    check32("fade_to_zero", ring_in, 32'h0);
    for (int i = 4; i < 9; i++) step(1'b0, 10'd0, 10'd0, 32'h12300000);
    step(1'b0, 10'd0, 10'd0, 32'h80000000);
    check32("no_fade_pass1", ring_in, 32'h80000000);

    // 17 pushes with no empty slots: full after 16, one drop.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 10'(i), 10'(i + 100), 32'h80000001);
      if (i == 15) check32("full_after_16", {31'h0, pixel_ready}, 32'h0);
    end
    check32("dropped_after_17", {16'h0, dropped_count}, STATS ? 32'h1 : 32'h0);

    // Reset with queued pixels discards them.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 10'(i + 1), 10'(i + 2), 32'h80000001);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 10'd0, 10'd0, 32'h0);
      check32("no_insert_after_reset", ring_in, 32'h0);
    end

    // Fade schedule: revolutions 0 and 2 fade, 1 and 3 pass through.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 10'd0, 10'd0, 32'h12345678);
      check32("fade_schedule", ring_in, ((k % 16) < 8) ? 32'h11345678 : 32'h12345678);
    end

    // Randomized traffic with alternating push pressure and one mid-run reset.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      pct = ((i / 500) % 2 == 0) ? 85 : 20;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 3) r[31:20] = 12'h000;
      else if (sel == 3) r[31:20] = 12'($urandom_range(1, 20));
      step(($urandom_range(0, 99) < pct), 10'($urandom), 10'($urandom), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
